// File: rtl/unidad_busqueda.sv
// -----------------------------------------------------------------------------
// unidad_busqueda: instruction-fetch unit and PC register for the MIPS32 path.
//
// Issues word-aligned requests to instruction memory, hands fetched words to
// decode, holds one extra word while decode is stalled, and redirects the PC
// on taken branches or jumps resolved in execute.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   SaltoCond, zero       conditional branch in execute and its ALU zero flag
//   Salto                 unconditional jump in execute (wins over a branch)
//   pc_salto_base         PC+4 of the branch/jump instruction
//   desp_salto            sign-extended branch offset, in words
//   dir_salto             26-bit jump target field
//   detener               decode stall: hold instr / instr_valida
//   imem_req, imem_dir    fetch request and word-aligned fetch address
//   imem_ack, imem_dato   request accepted; instruction word valid this cycle
//   instr, instr_valida   instruction presented to decode and its valid flag
//   pc_mas4               PC+4 of instr
//   ocupado               high while discarding a flushed fetch or buffering
// -----------------------------------------------------------------------------
module unidad_busqueda #(
  parameter int                   ANCHO_DIR = 32,
  parameter logic [ANCHO_DIR-1:0] PC_RESET  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SaltoCond,
  input  logic                 zero,
  input  logic                 Salto,
  input  logic [ANCHO_DIR-1:0] pc_salto_base,
  input  logic [ANCHO_DIR-1:0] desp_salto,
  input  logic [25:0]          dir_salto,
  input  logic                 detener,
  output logic                 imem_req,
  output logic [ANCHO_DIR-1:0] imem_dir,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_dato,
  output logic [31:0]          instr,
  output logic                 instr_valida,
  output logic [ANCHO_DIR-1:0] pc_mas4,
  output logic                 ocupado
);

  typedef enum logic [1:0] {
    INICIO,    // one idle cycle after reset
    BUSCA,     // request outstanding at imem_dir
    DESCARTE,  // redirected with a request in flight: wait for it, drop it
    LLENO      // decode stalled and the spare word is held in the buffer
  } estado_t;

  estado_t              estado;
  logic [ANCHO_DIR-1:0] pc;        // address of the next word to deliver
  logic [ANCHO_DIR-1:0] pc_sig;
  logic                 redirigir;
  logic [ANCHO_DIR-1:0] destino_rama;
  logic [ANCHO_DIR-1:0] destino_salto;
  logic [ANCHO_DIR-1:0] destino;
  logic                 entrega;   // accepted word goes straight to decode
  logic                 cargar_buffer;

  // Single-entry buffer. Whether it holds anything is implied by state LLENO.
  logic [31:0]          buf_instr;
  logic [ANCHO_DIR-1:0] buf_pc4;

  assign pc_sig        = pc + ANCHO_DIR'(4);
  assign redirigir     = Salto | (SaltoCond & zero);
  assign destino_rama  = pc_salto_base + (desp_salto << 2);
  assign destino_salto = {pc_salto_base[ANCHO_DIR-1:28], dir_salto, 2'b00};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    destino = destino_rama;
    if (Salto) destino = destino_salto;
    destino[1:0] = 2'b00;
  end

  // While the word in decode is stalled, the incoming word is parked in the
  // buffer; an empty (invalid) decode slot can simply be overwritten.
  assign entrega       = imem_ack & (~detener | ~instr_valida);
  assign cargar_buffer = (estado == BUSCA) & ~redirigir & imem_ack &
                         detener & instr_valida;

  // NOTE: the buffer data is deliberately not reset; it is only read in
  // LLENO, which can only be entered after it has been written.
  always_ff @(posedge clk) begin
    if (cargar_buffer) begin
      buf_instr <= imem_dato;
      buf_pc4   <= pc_sig;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the values from before this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= INICIO;
      pc           <= {PC_RESET[ANCHO_DIR-1:2], 2'b00};
      imem_req     <= 1'b0;
      imem_dir     <= '0;
      instr        <= '0;
      instr_valida <= 1'b0;
      pc_mas4      <= '0;
      ocupado      <= 1'b0;
    end else begin
      case (estado)
        INICIO: begin
          estado   <= BUSCA;
          imem_req <= 1'b1;
          if (redirigir) begin
            pc       <= destino;
            imem_dir <= destino;
          end else begin
            imem_dir <= pc;
          end
        end

        BUSCA: begin
          if (redirigir) begin
            pc           <= destino;
            instr_valida <= 1'b0;
            if (imem_ack) begin
              // The returning word is younger than the redirect: drop it.
              imem_dir <= destino;
            end else begin
              // Address must stay stable until the old request is accepted.
              estado  <= DESCARTE;
              ocupado <= 1'b1;
            end
          end else if (entrega) begin
            instr        <= imem_dato;
            pc_mas4      <= pc_sig;
            instr_valida <= 1'b1;
            pc           <= pc_sig;
            imem_dir     <= pc_sig;
          end else if (imem_ack) begin
            // Stalled with a valid word in decode: park the new one.
            pc       <= pc_sig;
            imem_req <= 1'b0;
            estado   <= LLENO;
            ocupado  <= 1'b1;
          end else if (!detener) begin
            instr_valida <= 1'b0;
          end
        end

        DESCARTE: begin
          if (redirigir) pc <= destino;
          if (imem_ack) begin
            estado   <= BUSCA;
            ocupado  <= 1'b0;
            imem_dir <= redirigir ? destino : pc;
          end
        end

        LLENO: begin
          if (redirigir) begin
            pc           <= destino;
            imem_dir     <= destino;
            imem_req     <= 1'b1;
            instr_valida <= 1'b0;
            estado       <= BUSCA;
            ocupado      <= 1'b0;
          end else if (!detener) begin
            instr        <= buf_instr;
            pc_mas4      <= buf_pc4;
            instr_valida <= 1'b1;
            imem_dir     <= pc;
            imem_req     <= 1'b1;
            estado       <= BUSCA;
            ocupado      <= 1'b0;
          end
        end

        default: begin
          estado   <= INICIO;
          imem_req <= 1'b0;
          ocupado  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_busqueda.sv
// -----------------------------------------------------------------------------
// tb_unidad_busqueda: self-checking bench for unidad_busqueda.
// Memory returns the word address as the instruction so every delivered
// instruction identifies itself. A second instance uses PC_RESET near the top
// of the address space to exercise wrap-around and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_unidad_busqueda;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SaltoCond, zero, Salto, detener, imem_ack;
  logic [31:0] pc_salto_base, desp_salto;
  logic [25:0] dir_salto;
  logic        imem_req, instr_valida, ocupado;
  logic [31:0] imem_dir, imem_dato, instr, pc_mas4;

  logic        rst_n_w;
  logic        cero_w = 1'b0;
  logic        uno_w  = 1'b1;
  logic [31:0] base_w = '0;
  logic [25:0] dir_w  = '0;
  logic        imem_req_w, instr_valida_w, ocupado_w;
  logic [31:0] imem_dir_w, imem_dato_w, instr_w, pc_mas4_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_dato   = imem_dir;
  assign imem_dato_w = imem_dir_w;

  unidad_busqueda dut (
    .clk(clk), .rst_n(rst_n), .SaltoCond(SaltoCond), .zero(zero),
    .Salto(Salto), .pc_salto_base(pc_salto_base), .desp_salto(desp_salto),
    .dir_salto(dir_salto), .detener(detener), .imem_req(imem_req),
    .imem_dir(imem_dir), .imem_ack(imem_ack), .imem_dato(imem_dato),
    .instr(instr), .instr_valida(instr_valida), .pc_mas4(pc_mas4),
    .ocupado(ocupado)
  );

  unidad_busqueda #(.ANCHO_DIR(32), .PC_RESET(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n_w), .SaltoCond(cero_w), .zero(cero_w),
    .Salto(cero_w), .pc_salto_base(base_w), .desp_salto(base_w),
    .dir_salto(dir_w), .detener(cero_w), .imem_req(imem_req_w),
    .imem_dir(imem_dir_w), .imem_ack(uno_w), .imem_dato(imem_dato_w),
    .instr(instr_w), .instr_valida(instr_valida_w), .pc_mas4(pc_mas4_w),
    .ocupado(ocupado_w)
  );

  task automatic check(input string nombre, input logic [31:0] obtenido,
                       input logic [31:0] esperado);
    checks++;
    if (obtenido !== esperado) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nombre, obtenido, esperado);
    end
  endtask

  task automatic limpiar();
    SaltoCond = 1'b0; zero = 1'b0; Salto = 1'b0; detener = 1'b0;
    imem_ack = 1'b0; pc_salto_base = '0; desp_salto = '0; dir_salto = '0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    limpiar();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        salto, cond, cero;
    logic [31:0] base, desp;
    logic [25:0] dir;
    logic [31:0] exp_dir;
    logic        exp_val;
  } vec_t;

  vec_t tabla [7];

  // Reference model state for the random run.
  logic [31:0] esperada;
  logic [31:0] destino_m;
  logic [31:0] dir_prev;
  logic        pend_prev, red, v_s, det;
  logic [31:0] instr_s, pc4_s, dir_s;
  logic        req_s;
  int          entregas;

  initial begin
    rst_n_w = 1'b0;
    limpiar();

    tabla[0] = '{1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFE, 26'h0,
                 32'h0000_0018, 1'b0};
    tabla[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'hFFFF_FFFE, 26'h0,
                 32'h0000_0004, 1'b1};
    tabla[2] = '{1'b1, 1'b1, 1'b1, 32'h9000_0004, 32'h0000_0005, 26'h100,
                 32'h9000_0400, 1'b0};
    tabla[3] = '{1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000, 26'h3FF_FFFF,
                 32'h1FFF_FFFC, 1'b0};
    tabla[4] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0000_0008, 26'h0,
                 32'h0000_0010, 1'b0};
    tabla[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0010, 26'h0,
                 32'h0000_0004, 1'b1};
    tabla[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0010, 26'h0,
                 32'h0000_0140, 1'b0};

    // ---- Reset state, then back-to-back fetch with ack tied high ----
    do_reset();
    check("rst_req", imem_req, 0);
    check("rst_dir", imem_dir, 0);
    check("rst_instr", instr, 0);
    check("rst_valida", instr_valida, 0);
    check("rst_pc4", pc_mas4, 0);
    check("rst_ocupado", ocupado, 0);
    imem_ack = 1'b1;
    @(negedge clk);
    check("t1_req", imem_req, 1);
    check("t1_dir0", imem_dir, 32'h0);
    check("t1_val0", instr_valida, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("t1_dir%0d", k), imem_dir, 32'(4 * k));
      check($sformatf("t1_val%0d", k), instr_valida, 1);
      check($sformatf("t1_instr%0d", k), instr, 32'(4 * (k - 1)));
      check($sformatf("t1_pc4_%0d", k), pc_mas4, 32'(4 * k));
    end

    // ---- Stall for 3 cycles while 0x8 is in decode ----
    detener = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_instr_held", instr, 32'h8);
      check("t2_valida", instr_valida, 1);
      check("t2_req_off", imem_req, 0);
      check("t2_ocupado", ocupado, 1);
    end
    detener = 1'b0;
    @(negedge clk);
    check("t2_buf_instr", instr, 32'hC);
    check("t2_buf_pc4", pc_mas4, 32'h10);
    check("t2_resume_dir", imem_dir, 32'h10);
    check("t2_resume_req", imem_req, 1);
    check("t2_ocupado_off", ocupado, 0);
    @(negedge clk);
    check("t2_next_instr", instr, 32'h10);

    // ---- Redirect target table, applied from a fresh first request ----
    for (int i = 0; i < 7; i++) begin
      do_reset();
      @(negedge clk);
      Salto = tabla[i].salto; SaltoCond = tabla[i].cond; zero = tabla[i].cero;
      pc_salto_base = tabla[i].base; desp_salto = tabla[i].desp;
      dir_salto = tabla[i].dir; imem_ack = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_dir", i), imem_dir, tabla[i].exp_dir);
      check($sformatf("vec%0d_valida", i), instr_valida, tabla[i].exp_val);
      check($sformatf("vec%0d_req", i), imem_req, 1);
      limpiar();
    end

    // ---- Redirect with the request still outstanding ----
    do_reset();
    @(negedge clk);
    Salto = 1'b1; dir_salto = 26'h100;
    @(negedge clk);
    limpiar();
    check("t5_req_held", imem_req, 1);
    check("t5_dir_held", imem_dir, 32'h0);
    check("t5_ocupado", ocupado, 1);
    check("t5_valida", instr_valida, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t5_wait_dir", imem_dir, 32'h0);
      check("t5_wait_valida", instr_valida, 0);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    check("t5_target_dir", imem_dir, 32'h400);
    check("t5_dropped", instr_valida, 0);
    check("t5_ocupado_off", ocupado, 0);
    @(negedge clk);
    check("t5_first_valida", instr_valida, 1);
    check("t5_first_instr", instr, 32'h400);
    check("t5_first_pc4", pc_mas4, 32'h404);

    // ---- Random traffic against the delivered-stream model ----
    do_reset();
    esperada = 32'h0; pend_prev = 1'b0; dir_prev = '0; entregas = 0;
    for (int c = 0; c < 3000; c++) begin
      v_s = instr_valida; instr_s = instr; pc4_s = pc_mas4;
      req_s = imem_req; dir_s = imem_dir;
      if (pend_prev) begin
        check("rnd_req_hold", 32'(req_s), 1);
        check("rnd_dir_hold", dir_s, dir_prev);
      end
      if (req_s) check("rnd_dir_align", 32'(dir_s[1:0]), 0);

      limpiar();
      det = ($urandom_range(3) == 0);
      detener = det;
      imem_ack = req_s && ($urandom_range(9) < 7);
      if ($urandom_range(15) == 0) begin
        case ($urandom_range(3))
          0: begin Salto = 1'b1; end
          1: begin SaltoCond = 1'b1; zero = 1'b1; end
          2: begin SaltoCond = 1'b1; zero = 1'b0; end
          default: begin Salto = 1'b1; SaltoCond = 1'b1; zero = 1'b1; end
        endcase
        pc_salto_base = $urandom & 32'hFFFF_FFFC;
        desp_salto = 32'($urandom_range(63)) - 32'd32;
        dir_salto = 26'($urandom);
      end
      red = Salto || (SaltoCond && zero);
      if (Salto)
        destino_m = (pc_salto_base & 32'hF000_0000) + 32'(dir_salto) * 4;
      else
        destino_m = pc_salto_base + desp_salto * 4;

      if (red) begin
        esperada = destino_m;
      end else if (v_s && !det) begin
        check("rnd_instr", instr_s, esperada);
        check("rnd_pc4", pc4_s, esperada + 32'd4);
        esperada = esperada + 32'd4;
        entregas++;
      end
      pend_prev = req_s && !imem_ack;
      dir_prev = dir_s;
      @(negedge clk);
    end
    check("rnd_progress", 32'(entregas > 300), 1);
    limpiar();

    // ---- Reset value near the top, wrap-around, async reset ----
    rst_n_w = 1'b1;
    check("t6_idle_req", imem_req_w, 0);
    @(negedge clk);
    check("t6_dir0", imem_dir_w, 32'hFFFF_FFF8);
    @(negedge clk);
    check("t6_dir1", imem_dir_w, 32'hFFFF_FFFC);
    check("t6_instr1", instr_w, 32'hFFFF_FFF8);
    @(negedge clk);
    check("t6_dir_wrap", imem_dir_w, 32'h0000_0000);
    check("t6_instr2", instr_w, 32'hFFFF_FFFC);
    check("t6_pc4_wrap", pc_mas4_w, 32'h0000_0000);
    check("t6_valida", instr_valida_w, 1);
    #2 rst_n_w = 1'b0;
    #1;
    check("t6_async_req", imem_req_w, 0);
    check("t6_async_instr", instr_w, 0);
    check("t6_async_valida", instr_valida_w, 0);
    check("t6_async_ocupado", ocupado_w, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
